regfile_scoreboard: RTL and testbench

- Architectural register storage and hazard tracker feeding the decode stage.
- Holds the integer bank x0..x31 and the RV32F bank f0..f31.
- Consumes the write-back port from the write stage and serves two combinational read ports to decode.
- Keeps one busy bit per register so decode can stall on RAW hazards until the producing instruction writes back.

---
 rtl/cpu_pkg.sv | 11 +
 rtl/regfile_scoreboard_scoreboard.sv | 42 ++++
 rtl/regfile_scoreboard.sv | 69 ++++++
 tb/tb_regfile_scoreboard.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, register index/bank types and a one-hot decode helper for the register file.
package cpu_pkg;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  typedef logic [4:0] reg_idx_t;
  typedef logic [XLEN-1:0] xlen_t;
  typedef enum logic {BANK_INT, BANK_FP} reg_bank_t;
  function automatic logic [NREG-1:0] onehot(input reg_idx_t i);
    return NREG'(1) << i;
  endfunction
endpackage

// File: rtl/regfile_scoreboard_scoreboard.sv
// scoreboard: per-register busy bits for the integer and float banks with set/clear/flush and two lookup ports.
module scoreboard
  import cpu_pkg::*;
(
  input  logic      clk,
  input  logic      rstn,
  input  logic      issue_valid,
  input  reg_idx_t  issue_dest,
  input  reg_bank_t issue_bank,
  input  logic      flush,
  input  logic      w_int,
  input  logic      w_fp,
  input  reg_idx_t  w_dest,
  input  reg_idx_t  r1_addr,
  input  reg_bank_t r1_bank,
  input  reg_idx_t  r2_addr,
  input  reg_bank_t r2_bank,
  output logic      r1_busy,
  output logic      r2_busy
);
  logic [NREG-1:0] busy_x, busy_f, set_x, set_f, clr_x, clr_f;
  always_comb begin
    set_x = (issue_valid && issue_bank == BANK_INT) ? onehot(issue_dest) & ~onehot('0) : '0;
    set_f = (issue_valid && issue_bank == BANK_FP) ? onehot(issue_dest) : '0;
    clr_x = w_int ? onehot(w_dest) : '0;
    clr_f = w_fp ? onehot(w_dest) : '0;
    r1_busy = r1_bank == BANK_FP ? busy_f[r1_addr] : busy_x[r1_addr];
    r2_busy = r2_bank == BANK_FP ? busy_f[r2_addr] : busy_x[r2_addr];
  end
  // set is applied after clear so a newer producer stays outstanding
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      busy_x <= '0;
      busy_f <= '0;
    end else if (flush) begin
      busy_x <= '0;
      busy_f <= '0;
    end else begin
      busy_x <= (busy_x & ~clr_x) | set_x;
      busy_f <= (busy_f & ~clr_f) | set_f;
    end
endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: x/f register banks with busy tracking; REGFILE_WRITE_BYPASS_EN forwards same-cycle write-back to reads.
module regfile_scoreboard
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rstn,
  input  logic            reg_w_enable,
  input  logic            freg_w_enable,
  input  logic [4:0]      reg_w_dest,
  input  logic [XLEN-1:0] reg_w_data,
  input  logic            issue_valid,
  input  logic [4:0]      issue_dest,
  input  logic            issue_is_f,
  input  logic            flush,
  input  logic [4:0]      r1_addr,
  input  logic            r1_is_f,
  input  logic [4:0]      r2_addr,
  input  logic            r2_is_f,
  output logic [XLEN-1:0] r1_data,
  output logic [XLEN-1:0] r2_data,
  output logic            r1_busy,
  output logic            r2_busy
);
  xlen_t regs [2][NREG];
  logic w_int, w_fp, hit1, hit2, busy1_raw, busy2_raw;
  assign w_int = reg_w_enable;
  assign w_fp = freg_w_enable && !reg_w_enable;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < NREG; i++)
          regs[b][i] <= '0;
    end else if (w_int) begin
      if (reg_w_dest != '0) regs[BANK_INT][reg_w_dest] <= reg_w_data;
    end else if (w_fp) begin
      regs[BANK_FP][reg_w_dest] <= reg_w_data;
    end
  scoreboard u_sb (
    .clk(clk),
    .rstn(rstn),
    .issue_valid(issue_valid),
    .issue_dest(issue_dest),
    .issue_bank(reg_bank_t'(issue_is_f)),
    .flush(flush),
    .w_int(w_int),
    .w_fp(w_fp),
    .w_dest(reg_w_dest),
    .r1_addr(r1_addr),
    .r1_bank(reg_bank_t'(r1_is_f)),
    .r2_addr(r2_addr),
    .r2_bank(reg_bank_t'(r2_is_f)),
    .r1_busy(busy1_raw),
    .r2_busy(busy2_raw)
  );
`ifdef REGFILE_WRITE_BYPASS_EN
  assign hit1 = ((w_int && !r1_is_f && reg_w_dest != '0) || (w_fp && r1_is_f)) && reg_w_dest == r1_addr;
  assign hit2 = ((w_int && !r2_is_f && reg_w_dest != '0) || (w_fp && r2_is_f)) && reg_w_dest == r2_addr;
`else
  assign hit1 = 1'b0;
  assign hit2 = 1'b0;
`endif
  always_comb begin
    r1_data = !rstn ? '0 : hit1 ? reg_w_data : regs[r1_is_f][r1_addr];
    r2_data = !rstn ? '0 : hit2 ? reg_w_data : regs[r2_is_f][r2_addr];
    r1_busy = rstn && !hit1 && busy1_raw;
    r2_busy = rstn && !hit2 && busy2_raw;
  end
  a_one_writer: assert property (@(posedge clk) disable iff (!rstn) !(reg_w_enable && freg_w_enable));
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed stimulus, per-cycle comparison against a bank/busy array model, plus literal spot checks.
module tb_regfile_scoreboard;
  logic clk, rstn, reg_w_enable, freg_w_enable, issue_valid, issue_is_f, flush, r1_is_f, r2_is_f;
  logic r1_busy, r2_busy;
  logic [4:0] reg_w_dest, issue_dest, r1_addr, r2_addr;
  logic [31:0] reg_w_data, r1_data, r2_data;
  int n_chk = 0, n_fail = 0;
  logic [31:0] m_reg [2][32];
  logic m_busy [2][32];
  logic wen, wbank;
  regfile_scoreboard dut (
    .clk(clk), .rstn(rstn), .reg_w_enable(reg_w_enable), .freg_w_enable(freg_w_enable),
    .reg_w_dest(reg_w_dest), .reg_w_data(reg_w_data), .issue_valid(issue_valid),
    .issue_dest(issue_dest), .issue_is_f(issue_is_f), .flush(flush),
    .r1_addr(r1_addr), .r1_is_f(r1_is_f), .r2_addr(r2_addr), .r2_is_f(r2_is_f),
    .r1_data(r1_data), .r2_data(r2_data), .r1_busy(r1_busy), .r2_busy(r2_busy)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask
  assign wen = reg_w_enable || freg_w_enable;
  assign wbank = !reg_w_enable;
  always @(posedge clk or negedge rstn)
    if (!rstn) begin
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < 32; i++) begin
          m_reg[b][i] <= 0;
          m_busy[b][i] <= 0;
        end
    end else begin
      if (wen && !(wbank == 0 && reg_w_dest == 0)) begin
        m_reg[wbank][reg_w_dest] <= reg_w_data;
        m_busy[wbank][reg_w_dest] <= 0;
      end
      if (flush) begin
        for (int b = 0; b < 2; b++)
          for (int i = 0; i < 32; i++)
            m_busy[b][i] <= 0;
      end else if (issue_valid && !(issue_is_f == 0 && issue_dest == 0))
        m_busy[issue_is_f][issue_dest] <= 1;
    end
  function automatic logic byp(input logic [4:0] a, input logic f);
`ifdef REGFILE_WRITE_BYPASS_EN
    return wen && wbank == f && reg_w_dest == a && !(f == 0 && a == 0);
`else
    return 1'b0;
`endif
  endfunction
  function automatic logic [31:0] exp_data(input logic [4:0] a, input logic f);
    if (!rstn) return 0;
    return byp(a, f) ? reg_w_data : m_reg[f][a];
  endfunction
  function automatic logic exp_busy(input logic [4:0] a, input logic f);
    return rstn && !byp(a, f) && m_busy[f][a];
  endfunction
  always @(negedge clk) begin
    check("model r1_data", r1_data, exp_data(r1_addr, r1_is_f));
    check("model r2_data", r2_data, exp_data(r2_addr, r2_is_f));
    check("model r1_busy", 32'(r1_busy), 32'(exp_busy(r1_addr, r1_is_f)));
    check("model r2_busy", 32'(r2_busy), 32'(exp_busy(r2_addr, r2_is_f)));
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    reg_w_enable = 0;
    freg_w_enable = 0;
    issue_valid = 0;
    flush = 0;
  endtask
  task automatic rd(input logic [4:0] a1, input logic f1, input logic [4:0] a2, input logic f2);
    r1_addr = a1;
    r1_is_f = f1;
    r2_addr = a2;
    r2_is_f = f2;
  endtask
  task automatic wr(input logic f, input logic [4:0] d, input logic [31:0] v);
    reg_w_enable = !f;
    freg_w_enable = f;
    reg_w_dest = d;
    reg_w_data = v;
  endtask
  task automatic iss(input logic f, input logic [4:0] d);
    issue_valid = 1;
    issue_is_f = f;
    issue_dest = d;
  endtask
  initial begin
    rstn = 0;
    idle();
    reg_w_dest = 0;
    reg_w_data = 0;
    issue_dest = 0;
    issue_is_f = 0;
    rd(5, 0, 5, 1);
    #12 rstn = 1;
    cyc();
    #1;
    check("reset x5 data", r1_data, 0);
    check("reset x5 busy", 32'(r1_busy), 0);
    check("reset f5 data", r2_data, 0);
    wr(0, 5, 32'hDEADBEEF);
    cyc();
    idle();
    #1;
    check("x5 after write", r1_data, 32'hDEADBEEF);
    check("f5 untouched", r2_data, 0);
    wr(0, 0, 32'h12345678);
    iss(0, 0);
    rd(0, 0, 0, 0);
    #1 check("x0 write-cycle data", r1_data, 0);
    cyc();
    idle();
    for (int k = 0; k < 3; k++) begin
      #1;
      check("x0 data", r1_data, 0);
      check("x0 busy", 32'(r1_busy), 0);
      cyc();
    end
    iss(1, 3);
    rd(3, 1, 3, 0);
    cyc();
    idle();
    for (int k = 1; k <= 3; k++) begin
      #1 check("f3 busy pending", 32'(r1_busy), 1);
      cyc();
    end
    wr(1, 3, 32'h3F800000);
    #1;
`ifdef REGFILE_WRITE_BYPASS_EN
    check("f3 wb-cycle data", r1_data, 32'h3F800000);
    check("f3 wb-cycle busy", 32'(r1_busy), 0);
`else
    check("f3 wb-cycle data", r1_data, 0);
    check("f3 wb-cycle busy", 32'(r1_busy), 1);
`endif
    cyc();
    idle();
    #1;
    check("f3 after wb data", r1_data, 32'h3F800000);
    check("f3 after wb busy", 32'(r1_busy), 0);
    check("x3 isolated", r2_data, 0);
    wr(0, 7, 32'hA);
    iss(0, 7);
    rd(7, 0, 7, 1);
    cyc();
    idle();
    #1;
    check("x7 data", r1_data, 32'hA);
    check("x7 set wins", 32'(r1_busy), 1);
    iss(0, 1);
    cyc();
    iss(0, 2);
    cyc();
    iss(1, 1);
    cyc();
    idle();
    rd(1, 0, 1, 1);
    #1;
    check("x1 busy pre-flush", 32'(r1_busy), 1);
    check("f1 busy pre-flush", 32'(r2_busy), 1);
    flush = 1;
    iss(0, 4);
    cyc();
    idle();
    #1;
    check("x1 busy post-flush", 32'(r1_busy), 0);
    check("f1 busy post-flush", 32'(r2_busy), 0);
    rd(2, 0, 4, 0);
    #1;
    check("x2 busy post-flush", 32'(r1_busy), 0);
    check("x4 flush beats issue", 32'(r2_busy), 0);
    for (int i = 0; i < 32; i++) begin
      wr(0, 5'(i), 32'(i) * 32'h01010101 + 1);
      iss(1'(i), 5'((i + 5) % 32));
      rd(5'(i), 0, 5'((i + 5) % 32), 1'(i));
      cyc();
    end
    for (int i = 0; i < 32; i++) begin
      wr(1, 5'(i), ~(32'(i) * 32'h00100401));
      issue_valid = 0;
      rd(5'((i + 5) % 32), 1'(i), 5'(i), 1);
      cyc();
    end
    idle();
    flush = 1;
    cyc();
    idle();
    wr(0, 9, 32'h1111);
    cyc();
    idle();
    wr(1, 9, 32'h2222);
    iss(0, 9);
    cyc();
    idle();
    rd(9, 0, 9, 1);
    #1;
    check("x9 bank isolation", r1_data, 32'h1111);
    check("f9 bank isolation", r2_data, 32'h2222);
    check("x9 busy pre-reset", 32'(r1_busy), 1);
    rstn = 0;
    #1;
    check("x9 async reset", r1_data, 0);
    check("f9 async reset", r2_data, 0);
    check("x9 busy async reset", 32'(r1_busy), 0);
    #20 rstn = 1;
    cyc();
    cyc();
    #1 check("x9 after reset", r1_data, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
